// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-4 Booth multiplier, two multiplier bits per clock, valid/ready on both sides
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);
  localparam int N  = WIDTH / 2 + 1;
  localparam int AW = 2 * WIDTH + 2;
  localparam int BW = WIDTH + 2;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t             r_state;
  logic [AW-1:0]      r_a;
  logic [AW-1:0]      r_acc;
  logic [BW-1:0]      r_b;
  logic               r_prev;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_prod;
  logic               r_out_valid;
  logic [AW-1:0]      w_a_ext;
  logic [BW-1:0]      w_b_ext;
  logic [2:0]         w_win;
  logic [AW-1:0]      w_pp;
  logic [AW-1:0]      w_acc_next;
  // Operands are widened at accept time so unsigned full-scale values stay positive under Booth recoding
  always_comb begin
    w_a_ext = {{(AW-WIDTH){is_signed & multiplicand[WIDTH-1]}}, multiplicand};
    w_b_ext = {{2{is_signed & multiplier[WIDTH-1]}}, multiplier};
  end
  // r_a is pre-shifted by 2i each step and r_b shifted down, so the window is always the low bits plus r_prev
  always_comb begin
    w_win      = {r_b[1:0], r_prev};
    w_pp       = (w_win == 3'b001 || w_win == 3'b010) ? r_a :
                 (w_win == 3'b011) ? (r_a << 1) :
                 (w_win == 3'b100) ? -(r_a << 1) :
                 (w_win == 3'b101 || w_win == 3'b110) ? -r_a : '0;
    w_acc_next = r_acc + w_pp;
  end
  // Control FSM and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_prev      <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_prod      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a     <= w_a_ext;
          r_b     <= w_b_ext;
          r_prev  <= 1'b0;
          r_acc   <= '0;
          r_cnt   <= '0;
          r_state <= CALC;
        end
        CALC: begin
          r_acc  <= w_acc_next;
          r_a    <= r_a << 2;
          r_b    <= {{2{r_b[BW-1]}}, r_b[BW-1:2]};
          r_prev <= r_b[1];
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == CW'(N - 1)) begin
            r_prod      <= w_acc_next[2*WIDTH-1:0];
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign product   = r_prod;
endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: scoreboard bench for 8-bit and 16-bit instances of the Booth multiplier
module tb_booth_mult_seq;
  localparam int N8  = 8 / 2 + 1;
  localparam int N16 = 16 / 2 + 1;
  typedef struct { logic [31:0] p; int acc; } exp_t;
  logic        clk = 1'b0;
  logic        rst;
  logic        iv8, ir8, sg8, ov8, or8, bz8;
  logic [7:0]  mc8, mr8;
  logic [15:0] p8;
  logic        iv16, ir16, sg16, ov16, or16, bz16;
  logic [15:0] mc16, mr16;
  logic [31:0] p16;
  logic        ov8_p, ov16_p;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        q8[$];
  exp_t        q16[$];

  booth_mult_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .is_signed(sg8),
    .multiplicand(mc8), .multiplier(mr8), .out_valid(ov8), .out_ready(or8),
    .product(p8), .busy(bz8)
  );
  booth_mult_seq #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .is_signed(sg16),
    .multiplicand(mc16), .multiplier(mr16), .out_valid(ov16), .out_ready(or16),
    .product(p16), .busy(bz16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_mul(logic [15:0] a, logic [15:0] b, bit s, int w);
    longint va, vb, p;
    va = longint'(a);
    vb = longint'(b);
    if (s && a[w-1]) va = va - (longint'(1) << w);
    if (s && b[w-1]) vb = vb - (longint'(1) << w);
    p = va * vb;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic go8(logic [7:0] a, logic [7:0] b, bit s);
    int t = 0;
    while (!ir8 && t < 100) begin tick(); t++; end
    chk("go8_ready", {31'b0, ir8}, 32'd1);
    iv8 = 1'b1; mc8 = a; mr8 = b; sg8 = s;
    q8.push_back('{ref_mul({8'h0, a}, {8'h0, b}, s, 8), cyc + 1});
    tick();
    iv8 = 1'b0;
    mc8 = 8'($urandom); mr8 = 8'($urandom); sg8 = 1'($urandom);
    chk("in_ready8_low", {31'b0, ir8}, 32'd0);
  endtask

  task automatic go16(logic [15:0] a, logic [15:0] b, bit s);
    int t = 0;
    while (!ir16 && t < 100) begin tick(); t++; end
    chk("go16_ready", {31'b0, ir16}, 32'd1);
    iv16 = 1'b1; mc16 = a; mr16 = b; sg16 = s;
    q16.push_back('{ref_mul(a, b, s, 16), cyc + 1});
    tick();
    iv16 = 1'b0;
    mc16 = 16'($urandom); mr16 = 16'($urandom); sg16 = 1'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while ((q8.size() != 0 || q16.size() != 0) && t < 300) begin tick(); t++; end
    chk("drain_pending", 32'(q8.size() + q16.size()), 32'd0);
    tick();
  endtask

  // Monitor: checks latency when out_valid rises and pops the scoreboard on each handshake
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      ov8_p  <= 1'b0;
      ov16_p <= 1'b0;
    end else begin
      if (ov8 && !ov8_p) begin
        if (q8.size() == 0) chk("unexpected_out8", 32'd1, 32'd0);
        else chk("latency8", 32'(cyc - q8[0].acc), 32'(N8));
      end
      if (ov8 && or8 && q8.size() != 0) begin
        e = q8.pop_front();
        chk("product8", {16'h0, p8}, e.p);
      end
      if (ov16 && !ov16_p) begin
        if (q16.size() == 0) chk("unexpected_out16", 32'd1, 32'd0);
        else chk("latency16", 32'(cyc - q16[0].acc), 32'(N16));
      end
      if (ov16 && or16 && q16.size() != 0) begin
        e = q16.pop_front();
        chk("product16", p16, e.p);
      end
      ov8_p  <= ov8;
      ov16_p <= ov16;
    end
  end

  initial begin
    int t;
    rst = 1'b1;
    iv8 = 1'b0; sg8 = 1'b0; mc8 = '0; mr8 = '0; or8 = 1'b1;
    iv16 = 1'b0; sg16 = 1'b0; mc16 = '0; mr16 = '0; or16 = 1'b1;
    repeat (3) tick();
    chk("rst_in_ready", {31'b0, ir8}, 32'd1);
    chk("rst_out_valid", {31'b0, ov8}, 32'd0);
    chk("rst_busy", {31'b0, bz8}, 32'd0);
    chk("rst_product", {16'h0, p8}, 32'd0);
    rst = 1'b0;
    tick();
    go8(8'd100, 8'd12, 1'b0);
    go8(8'd85, 8'd30, 1'b0);
    go8(8'd90, 8'd4, 1'b0);
    go8(8'd0, 8'd5, 1'b0);
    go8(8'hFF, 8'h7F, 1'b1);
    go8(8'h80, 8'h80, 1'b1);
    go8(8'h80, 8'h7F, 1'b1);
    go8(8'h7F, 8'h7F, 1'b1);
    go8(8'hFF, 8'h7F, 1'b0);
    drain();
    go8(8'd85, 8'd30, 1'b0);
    for (int i = 0; i < N8 - 2; i++) begin
      mc8 = 8'($urandom); mr8 = 8'($urandom); sg8 = 1'($urandom);
      chk("hold_busy8", {31'b0, bz8}, 32'd1);
      tick();
    end
    drain();
    or8 = 1'b0;
    go8(8'hFF, 8'hFF, 1'b0);
    t = 0;
    while (!ov8 && t < 50) begin tick(); t++; end
    for (int i = 0; i < 10; i++) begin
      chk("stall_product8", {16'h0, p8}, ref_mul(16'hFF, 16'hFF, 1'b0, 8));
      chk("stall_out_valid8", {31'b0, ov8}, 32'd1);
      chk("stall_in_ready8", {31'b0, ir8}, 32'd0);
      iv8 = ~iv8;
      mc8 = 8'($urandom); mr8 = 8'($urandom);
      tick();
    end
    iv8 = 1'b1;
    or8 = 1'b1;
    tick();
    iv8 = 1'b0;
    chk("done_no_accept_ready8", {31'b0, ir8}, 32'd1);
    chk("done_no_accept_busy8", {31'b0, bz8}, 32'd0);
    chk("handshake_out_valid8", {31'b0, ov8}, 32'd0);
    chk("held_product8", {16'h0, p8}, ref_mul(16'hFF, 16'hFF, 1'b0, 8));
    drain();
    go8(8'd100, 8'd12, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("abort_out_valid8", {31'b0, ov8}, 32'd0);
    chk("abort_busy8", {31'b0, bz8}, 32'd0);
    chk("abort_in_ready8", {31'b0, ir8}, 32'd1);
    chk("abort_product8", {16'h0, p8}, 32'd0);
    q8.delete();
    tick();
    rst = 1'b0;
    tick();
    go8(8'd90, 8'd4, 1'b0);
    drain();
    go16(16'h8000, 16'h8000, 1'b1);
    go16(16'hFFFF, 16'hFFFF, 1'b0);
    for (int i = 0; i < 40; i++) go16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    go16(16'h8000, 16'h7FFF, 1'b1);
    go16(16'hFFFF, 16'h0001, 1'b1);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
Parametrised, sequential radix-4 Booth multiplier with a valid/ready handshake on both sides and a per-operation signed/unsigned mode. It is the multi-cycle, area-lean successor to the 8-bit combinational Booth multiplier. It is used in the CNN datapath where one multiplier is time-shared across MAC operations. It retires two multiplier bits per clock and holds its result until the consumer accepts it.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 4; product is 2*WIDTH bits.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair and mode are valid
in_ready  output  1  block can accept an operation (high only in IDLE)
is_signed  input  1  1 = two's-complement operands; 0 = unsigned operands
multiplicand  input  WIDTH  operand A
multiplier  input  WIDTH  operand B
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
product  output  2*WIDTH  A*B, two's complement if is_signed, else unsigned
busy  output  1  high in CALC or DONE

Behaviour:
- Reset (asynchronous, while rst=1): state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, internal accumulator, operand registers and counter cleared. Reset mid-CALC or mid-DONE aborts the operation; no output is produced for it.
- Let N = WIDTH/2 + 1 (N=5 for WIDTH=8).
- FSM states:
  - IDLE: in_ready=1. On a rising edge with in_valid=1, latch the operands. Extend both operands to WIDTH+2 bits: sign-extend if is_signed, zero-extend otherwise. Clear the accumulator, counter=0, go to CALC.
  - CALC: in_ready=0, busy=1. Each edge examines the 3-bit Booth window {b[2i+1], b[2i], b[2i-1]} of the extended multiplier, with b[-1]=0. The window selects 0, +A, +2A, -A or -2A. That partial product, shifted left by 2i, is added to the 2*WIDTH+2-bit accumulator, and counter increments. After the N-th iteration, go to DONE.
  - DONE: out_valid=1, product = accumulator[2*WIDTH-1:0], held stable while out_valid=1 and out_ready=0. On an edge with out_ready=1, clear out_valid and go to IDLE.
- Latency: out_valid rises exactly N clock edges after the accepting edge.
- Minimum issue interval: N+2 cycles (accept edge, N CALC edges, handshake edge in DONE). No new operation is accepted in DONE, even if out_ready and in_valid are both high on the same edge.
- Inputs are sampled only on the accepting edge. Changes to multiplicand, multiplier or is_signed afterwards have no effect on the current operation.
- Arithmetic: the result is exact for all operand pairs in both modes. Examples: signed -2^(WIDTH-1) * -2^(WIDTH-1) = 2^(2*WIDTH-2); unsigned (2^WIDTH-1)^2 fits in 2*WIDTH bits. No overflow or saturation.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- product keeps its last value after the handshake until the next DONE. It is 0 only after reset.

Test Plan:
- WIDTH=8, unsigned. Stimulus: 100*12, 85*30, 90*4, 0*5. Response: product = 1200, 2550, 360, 0 respectively; out_valid rises exactly 5 edges after each accept; in_ready is low from accept until return to IDLE.
- WIDTH=8, signed. Stimulus: -1*127, -128*-128, -128*127, 127*127. Response: product = 16'hFF81, 16'h4000, 16'hC080, 16'h3F01. Same operand bits with is_signed=0: 0xFF*0x7F = 16'h7E81.
- Backpressure. Stimulus: hold out_ready=0 for 10 cycles after out_valid rises on 255*255 unsigned. Response: product stays 16'hFE01 and out_valid stays 1; in_valid pulses during the stall are ignored (in_ready=0). Raising out_ready completes the handshake, and IDLE is re-entered on the next edge.
- Input hold. Stimulus: change multiplicand and multiplier every cycle during CALC after accepting 85*30. Response: product = 2550.
- Reset mid-op. Stimulus: assert rst asynchronously 2 cycles into CALC. Response: out_valid=0, busy=0, in_ready=1 and product=0 immediately, without waiting for a clock edge. The next operation 90*4 returns 360 with normal latency.
- WIDTH=16. Stimulus: random signed and unsigned pairs back-to-back with out_ready=1, plus the corners -32768*-32768 and 65535*65535. Response: products match the reference model (32'h40000000, 32'hFFFE0001); out_valid rises 9 edges after each accept.
